// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit with selectable operation, result flags and
// valid/ready flow control. Each stage holds one beat; bubbles collapse so an
// empty stage refills even while stages further downstream are stalled.
module bitwise_logic_pipe #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   localparam int OCC_W = $clog2(STAGES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             parity,
   output logic [OCC_W-1:0] occupancy
);

   // Result of the combinational compute stage
   logic [WIDTH-1:0] res_c;
   logic             zero_c;
   logic             parity_c;

   // Per-stage state; an invalid stage always carries zero data and flags
   logic [STAGES-1:0] valid_q;
   logic [WIDTH-1:0]  data_q [STAGES];
   logic [STAGES-1:0] zero_q;
   logic [STAGES-1:0] parity_q;

   // Per-stage next values, selected between new operands and the upstream stage
   logic [STAGES-1:0] valid_d;
   logic [WIDTH-1:0]  data_d [STAGES];
   logic [STAGES-1:0] zero_d;
   logic [STAGES-1:0] parity_d;

   logic [STAGES-1:0] load_c;
   logic              accept_c;
   logic [OCC_W-1:0]  occ_c;

   // Bitwise operation select and result flags
   always_comb begin
      res_c = a;
      case (op)
         3'b000:  res_c = ~a;
         3'b001:  res_c = a & b;
         3'b010:  res_c = a | b;
         3'b011:  res_c = a ^ b;
         3'b100:  res_c = ~(a & b);
         3'b101:  res_c = ~(a | b);
         3'b110:  res_c = ~(a ^ b);
         default: res_c = a;
      endcase
      zero_c   = ~|res_c;
      parity_c = ^res_c;
   end

   // Load chain: a stage loads when empty or when the stage below it advances;
   // the consumer's out_ready is the downstream of the last stage
   always_comb begin
      logic nxt;
      nxt    = out_ready;
      load_c = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         load_c[i] = !valid_q[i] || nxt;
         nxt       = load_c[i];
      end
   end

   // Nothing is accepted while reset is asserted
   assign in_ready = load_c[0] && !rst;
   assign accept_c = in_valid && in_ready;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_src
         if (gi == 0) begin : g_head
            assign valid_d[gi]  = accept_c;
            assign data_d[gi]   = accept_c ? res_c : '0;
            assign zero_d[gi]   = accept_c && zero_c;
            assign parity_d[gi] = accept_c && parity_c;
         end else begin : g_body
            assign valid_d[gi]  = valid_q[gi-1];
            assign data_d[gi]   = data_q[gi-1];
            assign zero_d[gi]   = zero_q[gi-1];
            assign parity_d[gi] = parity_q[gi-1];
         end
      end
   endgenerate

   // Stage registers: clear on reset, otherwise load the selected source
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= '0;
         zero_q   <= '0;
         parity_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (load_c[i]) begin
               valid_q[i]  <= valid_d[i];
               data_q[i]   <= data_d[i];
               zero_q[i]   <= zero_d[i];
               parity_q[i] <= parity_d[i];
            end
         end
      end
   end

   // Number of occupied stages
   always_comb begin
      occ_c = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_c = occ_c + OCC_W'(valid_q[i]);
      end
   end

   assign occupancy = occ_c;
   assign out_valid = valid_q[STAGES-1];
   assign out       = data_q[STAGES-1];
   assign zero      = zero_q[STAGES-1];
   assign parity    = parity_q[STAGES-1];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: three instances (32x2, 1x1, 24x4).
module tb_bitwise_logic_pipe;

   typedef struct {
      logic [31:0] d;
      logic        z;
      logic        p;
      int          cyc;   // expected presentation cycle, -1 = not checked
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   // Instance 0: WIDTH=32, STAGES=2
   logic        v0, rdy0, ov0, or0, z0, p0;
   logic [2:0]  op0;
   logic [31:0] a0, b0, out0;
   logic [1:0]  occ0;

   // Instance 1: WIDTH=1, STAGES=1
   logic        v1, rdy1, ov1, or1, z1, p1;
   logic [2:0]  op1;
   logic        a1, b1, out1;
   logic [0:0]  occ1;

   // Instance 2: WIDTH=24, STAGES=4
   logic        v2, rdy2, ov2, or2, z2, p2;
   logic [2:0]  op2;
   logic [23:0] a2, b2, out2;
   logic [2:0]  occ2;

   bitwise_logic_pipe #(.WIDTH(32), .STAGES(2)) dut0 (
      .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .op(op0), .a(a0), .b(b0),
      .out_valid(ov0), .out_ready(or0), .out(out0), .zero(z0), .parity(p0), .occupancy(occ0));

   bitwise_logic_pipe #(.WIDTH(1), .STAGES(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .op(op1), .a(a1), .b(b1),
      .out_valid(ov1), .out_ready(or1), .out(out1), .zero(z1), .parity(p1), .occupancy(occ1));

   bitwise_logic_pipe #(.WIDTH(24), .STAGES(4)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .op(op2), .a(a2), .b(b2),
      .out_valid(ov2), .out_ready(or2), .out(out2), .zero(z2), .parity(p2), .occupancy(occ2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, expv, cyc);
      end else begin
         $display("ok   %s = %h (cycle %0d)", nm, act, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one beat to instance 0; must be called just after a rising edge
   task automatic send0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic ez, input logic ep,
                        input bit push, input bit lat);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      v0 = 1'b1; op0 = op; a0 = a; b0 = b;
      do begin
         @(negedge clk);
         ok = rdy0;
         @(posedge clk);
         n++;
      end while (!ok && n < 50);
      #1;
      v0 = 1'b0;
      chk("dut0_accept", 32'(ok), 32'd1);
      if (push) q0.push_back('{ed, ez, ep, lat ? cyc + 1 : -1});
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < limit) begin
         tick();
         n++;
      end
   endtask

   // Monitors: pop and compare on every output transfer
   always @(negedge clk) begin
      if (!rst && ov0 && or0) begin
         if (q0.size() == 0) begin
            chk("dut0_unexpected_beat", out0, 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = q0.pop_front();
            chk("dut0_out", out0, e.d);
            chk("dut0_zero", 32'(z0), 32'(e.z));
            chk("dut0_parity", 32'(p0), 32'(e.p));
            if (e.cyc >= 0) chk("dut0_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov1 && or1) begin
         if (q1.size() == 0) begin
            chk("dut1_unexpected_beat", 32'(out1), 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("dut1_out", 32'(out1), e.d);
            chk("dut1_zero", 32'(z1), 32'(e.z));
            chk("dut1_parity", 32'(p1), 32'(e.p));
            if (e.cyc >= 0) chk("dut1_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov2 && or2) begin
         if (q2.size() == 0) begin
            chk("dut2_unexpected_beat", 32'(out2), 32'hxxxx_xxxx);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("dut2_out", 32'(out2), e.d);
            chk("dut2_zero", 32'(z2), 32'(e.z));
            chk("dut2_parity", 32'(p2), 32'(e.p));
            if (e.cyc >= 0) chk("dut2_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   // Hand-computed op sweep results for a=F0F0_1234, b=0FF0_FFFF
   logic [31:0] sweep_res [8];
   logic        sweep_par [8];
   logic [31:0] bp_val [5];
   logic        bp_par [5];

   initial begin
      logic [2:0] ops1 [6];
      logic       a1v  [6];
      logic       b1v  [6];
      logic       e1v  [6];

      sweep_res[0] = 32'h0F0F_EDCB; sweep_par[0] = 1'b1;
      sweep_res[1] = 32'h00F0_1234; sweep_par[1] = 1'b1;
      sweep_res[2] = 32'hFFF0_FFFF; sweep_par[2] = 1'b0;
      sweep_res[3] = 32'hFF00_EDCB; sweep_par[3] = 1'b1;
      sweep_res[4] = 32'hFF0F_EDCB; sweep_par[4] = 1'b1;
      sweep_res[5] = 32'h000F_0000; sweep_par[5] = 1'b0;
      sweep_res[6] = 32'h00FF_1234; sweep_par[6] = 1'b1;
      sweep_res[7] = 32'hF0F0_1234; sweep_par[7] = 1'b1;

      bp_val[0] = 32'h1; bp_par[0] = 1'b1;
      bp_val[1] = 32'h2; bp_par[1] = 1'b1;
      bp_val[2] = 32'h3; bp_par[2] = 1'b0;
      bp_val[3] = 32'h4; bp_par[3] = 1'b1;
      bp_val[4] = 32'h5; bp_par[4] = 1'b0;

      ops1[0] = 3'b000; a1v[0] = 1'b0; b1v[0] = 1'b0; e1v[0] = 1'b1;
      ops1[1] = 3'b001; a1v[1] = 1'b1; b1v[1] = 1'b1; e1v[1] = 1'b1;
      ops1[2] = 3'b101; a1v[2] = 1'b0; b1v[2] = 1'b0; e1v[2] = 1'b1;
      ops1[3] = 3'b011; a1v[3] = 1'b1; b1v[3] = 1'b1; e1v[3] = 1'b0;
      ops1[4] = 3'b110; a1v[4] = 1'b1; b1v[4] = 1'b0; e1v[4] = 1'b0;
      ops1[5] = 3'b010; a1v[5] = 1'b0; b1v[5] = 1'b0; e1v[5] = 1'b0;

      checks = 0; failures = 0;
      rst = 1'b1;
      v0 = 0; op0 = 0; a0 = 0; b0 = 0; or0 = 1;
      v1 = 0; op1 = 0; a1 = 0; b1 = 0; or1 = 1;
      v2 = 0; op2 = 0; a2 = 0; b2 = 0; or2 = 1;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(ov0), 32'd0);
      chk("rst_out", out0, 32'd0);
      chk("rst_zero", 32'(z0), 32'd0);
      chk("rst_parity", 32'(p0), 32'd0);
      chk("rst_occupancy", 32'(occ0), 32'd0);
      chk("rst_in_ready", 32'(rdy0), 32'd1);
      chk("rst_dut2_occupancy", 32'(occ2), 32'd0);
      tick();

      // Op sweep, one beat per cycle, latency checked
      for (int i = 0; i < 8; i++) begin
         send0(3'(i), 32'hF0F0_1234, 32'h0FF0_FFFF, sweep_res[i], 1'b0, sweep_par[i], 1'b1, 1'b1);
      end
      // Flag corners
      send0(3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      send0(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1);
      drain(20);

      // Backpressure: five beats against a stalled consumer
      or0 = 1'b0;
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               send0(3'b111, bp_val[i], 32'h0, bp_val[i], 1'b0, bp_par[i], 1'b1, 1'b0);
            end
         end
         begin
            repeat (4) @(posedge clk);
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("bp_occupancy", 32'(occ0), 32'd2);
               chk("bp_in_ready", 32'(rdy0), 32'd0);
               chk("bp_out_valid", 32'(ov0), 32'd1);
               chk("bp_out_hold", out0, bp_val[0]);
            end
            tick();
            or0 = 1'b1;
         end
      join
      drain(30);

      // Bubble collapse: one beat stalled at the output, stage 0 empty
      or0 = 1'b0;
      send0(3'b111, 32'h80, 32'h0, 32'h80, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      @(negedge clk);
      chk("bubble_occupancy1", 32'(occ0), 32'd1);
      chk("bubble_in_ready", 32'(rdy0), 32'd1);
      tick();
      send0(3'b111, 32'h3, 32'h0, 32'h3, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("bubble_occupancy2", 32'(occ0), 32'd2);
      tick();
      or0 = 1'b1;
      drain(20);

      // Mid-stream reset with a full pipe; the two beats must never emerge
      or0 = 1'b0;
      send0(3'b111, 32'hAAAA_0001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      send0(3'b111, 32'hAAAA_0002, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      chk("prerst_occupancy", 32'(occ0), 32'd2);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", 32'(ov0), 32'd0);
      chk("midrst_occupancy", 32'(occ0), 32'd0);
      chk("midrst_out", out0, 32'd0);
      chk("midrst_in_ready", 32'(rdy0), 32'd1);
      tick();
      or0 = 1'b1;
      repeat (6) tick();
      send0(3'b010, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 1'b1);
      drain(20);

      // WIDTH=1, STAGES=1: back-to-back beats, presented after the accepting edge
      for (int i = 0; i < 6; i++) begin
         v1 = 1'b1; op1 = ops1[i]; a1 = a1v[i]; b1 = b1v[i];
         @(negedge clk);
         chk("dut1_in_ready", 32'(rdy1), 32'd1);
         tick();
         q1.push_back('{32'(e1v[i]), !e1v[i], e1v[i], cyc});
      end
      v1 = 1'b0;

      // WIDTH=24, STAGES=4: three back-to-back beats, four-cycle latency
      v2 = 1'b1; op2 = 3'b001; a2 = 24'hFF_FFFF; b2 = 24'h12_3456;
      tick(); q2.push_back('{32'h0012_3456, 1'b0, 1'b1, cyc + 3});
      op2 = 3'b000; a2 = 24'h00_0000; b2 = 24'h00_0000;
      tick(); q2.push_back('{32'h00FF_FFFF, 1'b0, 1'b0, cyc + 3});
      op2 = 3'b100; a2 = 24'hFF_FFFF; b2 = 24'hFF_FFFF;
      tick(); q2.push_back('{32'h0000_0000, 1'b1, 1'b0, cyc + 3});
      v2 = 1'b0;
      @(negedge clk);
      chk("dut2_occupancy3", 32'(occ2), 32'd3);
      tick();

      drain(50);
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      chk("q2_empty", 32'(q2.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bitwise_logic_pipe.md
Name: bitwise_logic_pipe

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the fixed-width structural inverter family.
- Generalises width and pipeline depth, and adds operation select (NOT/AND/OR/XOR/NAND/NOR/XNOR/PASS), result flags and valid/ready flow control with backpressure.
- Sits between an operand source and a datapath consumer; slots into any streaming path that needs registered bitwise ops.

Parameters:
- WIDTH, 32, operand/result width in bits (≥1).
- STAGES, 2, pipeline register stages (≥1); zero-stall latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts beat this cycle.
- op  input  3  operation select, sampled with operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for op 000 and 111.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts result this cycle.
- out  output  WIDTH  result.
- zero  output  1  out == 0.
- parity  output  1  XOR-reduction of out (1 = odd ones count).
- occupancy  output  $clog2(STAGES+1)  number of valid stages in flight.

Behaviour:
- Op encoding: 000 ~a; 001 a&b; 010 a|b; 011 a^b; 100 ~(a&b); 101 ~(a|b); 110 ~(a^b); 111 a. All codes defined; none illegal.
- Transfer rules: input beat transfers when in_valid && in_ready; output beat transfers when out_valid && out_ready.
- Compute stage:
  - Result, zero and parity are computed combinationally from a, b and op.
  - They are captured into stage 0 on transfer.
  - Later stages copy them forward unchanged.
- Stage advance:
  - Stage i loads when its valid is 0 or stage i+1 is advancing. The downstream of the last stage is out_ready.
  - in_ready = stage-0 load condition, which is combinational from out_ready through the chain.
  - Bubbles collapse: an empty stage fills even while stages further downstream are stalled.
- Throughput and latency:
  - Full throughput: one beat per cycle with out_ready held high.
  - Latency is STAGES cycles from input transfer to out_valid when there is no stall. For STAGES=1, a beat accepted at edge N is presented after edge N.
- Output hold:
  - While out_valid && !out_ready, out/zero/parity/out_valid stay stable.
  - out_valid may not drop without a transfer.
- Ordering: strict FIFO; no reordering, drops or duplication.
- Occupancy: count of set stage valids, updated on the same edge as the stage valids.
  - Full: occupancy == STAGES and !out_ready ⇒ in_ready = 0.
  - Empty: occupancy == 0 ⇒ out_valid = 0 and in_ready = 1.
- Simultaneous events: with a full pipe and out_ready = 1, output and input transfer on the same edge; occupancy is unchanged.
- Reset:
  - Applies on any edge with rst=1, including mid-stream.
  - All stage valids clear and data/flag registers clear, so out = 0, zero = 0, parity = 0, out_valid = 0, occupancy = 0.
  - Flags read 0 while invalid.
  - in_ready is 1 in the cycle after reset, if out_ready is irrelevant by emptiness.
  - No input is accepted in a cycle with rst=1, and in-flight beats are discarded.
- Reset value of every output:
  - out_valid = 0, out = 0, zero = 0, parity = 0, occupancy = 0.
  - in_ready = 1 once rst deasserts.

Test Plan:
- Op sweep, WIDTH=32, STAGES=2, out_ready=1, a=0xF0F0_1234, b=0x0FF0_FFFF, op 000..111 on consecutive cycles.
  - Required outputs 2 cycles later, in order: 0x0F0F_EDCB, 0x00F0_1234, 0xFFF0_FFFF, 0xFF00_EDCB, 0xFF0F_EDCB, 0x000F_0000, 0x00FF_1234, 0xF0F0_1234.
  - One per cycle; parity and zero match each result.
- Flags: op=011 with a=b=0xDEAD_BEEF gives out=0, zero=1, parity=0. op=111 with a=0x0000_0001 gives zero=0, parity=1.
- Backpressure:
  - Stream 5 beats and hold out_ready=0 from cycle 1. occupancy reaches 2, in_ready=0, and out holds beat 0 stably.
  - Release out_ready: beats 0–4 emerge in order with no loss or duplication.
- Bubble collapse: one beat stalled at output with out_ready=0 and stage 0 empty. A new beat is accepted (in_ready=1), giving occupancy=2.
- Mid-stream reset: assert rst for 1 cycle with occupancy=2.
  - Next cycle: out_valid=0, occupancy=0, out=0, in_ready=1.
  - No pre-reset beat ever appears at the output.
- Parameter corners:
  - WIDTH=1, STAGES=1: op=000 with a=0 gives out=1 one cycle later; full throughput with out_ready=1.
  - WIDTH=24, STAGES=4: latency is 4 cycles.
